// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with burst/lock protection and registered grant, owner and lock outputs.
// Define ARB_FIXED_PRIORITY_EN for fixed priority (lowest requesting index wins) instead of round-robin.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic                   HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [2:0]             HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [2:0]             hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [4:0]             beats_left_q, beats_left_d;
  logic                   incr_q, incr_d;
`ifndef ARB_FIXED_PRIORITY_EN
  logic [2:0]             last_owner_q, last_owner_d;
`endif

  logic       fixed_burst;
  logic [4:0] burst_len_m1;
  logic       owner_lock;
  logic       owner_req;
  logic [2:0] grant_idx;
  logic       hold;
  logic       rearb;
  logic [2:0] win_idx;
  logic       win_valid;

  always_comb begin
    fixed_burst  = (HBURST[2:1] != 2'b00);
    burst_len_m1 = 5'd0;
    case (HBURST[2:1])
      2'b01:   burst_len_m1 = 5'd3;
      2'b10:   burst_len_m1 = 5'd7;
      2'b11:   burst_len_m1 = 5'd15;
      default: burst_len_m1 = 5'd0;
    endcase

    owner_lock = 1'b0;
    owner_req  = 1'b0;
    grant_idx  = 3'd0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hmaster_q == 3'(i)) begin
        owner_lock = HLOCK[i];
        owner_req  = HBUSREQ[i];
      end
      if (hgrant_q[i]) grant_idx = 3'(i);
    end

    beats_left_d = beats_left_q;
    incr_d       = incr_q;
    if (HREADY) begin
      case (HTRANS)
        TRANS_NONSEQ: begin
          beats_left_d = fixed_burst ? burst_len_m1 : 5'd0;
          incr_d       = (HBURST == BURST_INCR);
        end
        TRANS_SEQ: begin
          beats_left_d = (beats_left_q != 5'd0) ? beats_left_q - 5'd1 : 5'd0;
          incr_d       = (HBURST == BURST_INCR);
        end
        default: ;
      endcase
    end else if (HRESP) begin
      // An ERROR response aborts the burst so the next ready edge may hand the bus over.
      beats_left_d = 5'd0;
    end

    hold = (hmastlock_q && owner_lock)
        || (beats_left_d > 5'd1)
        || (incr_d && owner_req)
        || ((HTRANS == TRANS_BUSY) && fixed_burst && (beats_left_q != 5'd0));
    rearb = HREADY && !hold;

    win_idx   = 3'(DEFAULT_MASTER);
    win_valid = 1'b0;
`ifdef ARB_FIXED_PRIORITY_EN
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (HBUSREQ[i]) begin
        win_idx   = 3'(i);
        win_valid = 1'b1;
      end
    end
`else
    // Search starts just after the previous real winner and wraps, so the last owner goes last.
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!win_valid && HBUSREQ[j] && (j == (int'(last_owner_q) + i) % NUM_MASTERS)) begin
          win_idx   = 3'(j);
          win_valid = 1'b1;
        end
      end
    end
    last_owner_d = (rearb && win_valid) ? win_idx : last_owner_q;
`endif

    hgrant_d = hgrant_q;
    if (rearb) begin
      hgrant_d = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (win_idx == 3'(i)) hgrant_d[i] = 1'b1;
      end
    end

    hmaster_d   = HREADY ? grant_idx : hmaster_q;
    hmastlock_d = HREADY ? |(HLOCK & hgrant_q) : hmastlock_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hgrant_q     <= DEFAULT_GRANT;
      hmaster_q    <= 3'(DEFAULT_MASTER);
      hmastlock_q  <= 1'b0;
      beats_left_q <= 5'd0;
      incr_q       <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_owner_q <= 3'(DEFAULT_MASTER);
`endif
    end else begin
      hgrant_q     <= hgrant_d;
      hmaster_q    <= hmaster_d;
      hmastlock_q  <= hmastlock_d;
      beats_left_q <= beats_left_d;
      incr_q       <= incr_d;
`ifndef ARB_FIXED_PRIORITY_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign HGRANT    = hgrant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed cycles push expected grant/owner/lock, popped after each edge.
module tb_ahb_bus_arbiter;

  localparam int N = 4;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] INCR8  = 3'b101;
  localparam logic [2:0] INCR16 = 3'b111;

  typedef struct {
    logic [N-1:0] grant;
    logic [2:0]   master;
    logic         lock;
    string        tag;
  } exp_t;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [N-1:0] HBUSREQ;
  logic [N-1:0] HLOCK;
  logic [1:0]   HTRANS;
  logic [2:0]   HBURST;
  logic         HREADY;
  logic         HRESP;
  logic [N-1:0] HGRANT;
  logic [2:0]   HMASTER;
  logic         HMASTLOCK;

  int   checks = 0;
  int   errors = 0;
  exp_t scoreboard[$];

  ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of bus inputs, queue the state expected after the edge, then retire it.
  task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] lck,
                               input logic [1:0] trans, input logic [2:0] burst,
                               input logic rdy, input logic rsp,
                               input logic [N-1:0] e_grant, input logic [2:0] e_master,
                               input logic e_lock, input string tag);
    exp_t e;
    HBUSREQ = req;
    HLOCK   = lck;
    HTRANS  = trans;
    HBURST  = burst;
    HREADY  = rdy;
    HRESP   = rsp;
    e.grant  = e_grant;
    e.master = e_master;
    e.lock   = e_lock;
    e.tag    = tag;
    scoreboard.push_back(e);
    @(posedge HCLK);
    #1;
    if (scoreboard.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = scoreboard.pop_front();
      checkOutput({e.tag, "_grant"}, 32'(HGRANT), 32'(e.grant));
      checkOutput({e.tag, "_master"}, 32'(HMASTER), 32'(e.master));
      checkOutput({e.tag, "_lock"}, 32'(HMASTLOCK), 32'(e.lock));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    HRESETn = 1'b0;
    HBUSREQ = '0;
    HLOCK   = '0;
    HTRANS  = IDLE;
    HBURST  = SINGLE;
    HREADY  = 1'b1;
    HRESP   = 1'b0;
    #12;
    checkOutput("rst_grant", 32'(HGRANT), 32'h1);
    checkOutput("rst_master", 32'(HMASTER), 32'h0);
    checkOutput("rst_lock", 32'(HMASTLOCK), 32'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    applyStimulus(4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 3'd0, 0, "park0");
    applyStimulus(4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 3'd0, 0, "park1");

    applyStimulus(4'b1110, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b0010, 3'd0, 0, "rr1");
    applyStimulus(4'b1110, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b0100, 3'd1, 0, "rr2");
    applyStimulus(4'b1110, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b1000, 3'd2, 0, "rr3");
    applyStimulus(4'b1110, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b0010, 3'd3, 0, "rr4");
    applyStimulus(4'b0000, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0001, 3'd1, 0, "rr_drop");
    applyStimulus(4'b0000, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0001, 3'd0, 0, "rr_park");

    applyStimulus(4'b0100, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0100, 3'd0, 0, "b4_req");
    applyStimulus(4'b0100, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0100, 3'd2, 0, "b4_own");
    applyStimulus(4'b0101, 4'b0000, NONSEQ, INCR4,  1, 0, 4'b0100, 3'd2, 0, "b4_beat1");
    applyStimulus(4'b0101, 4'b0000, SEQ,    INCR4,  1, 0, 4'b0100, 3'd2, 0, "b4_beat2");
    applyStimulus(4'b0101, 4'b0000, SEQ,    INCR4,  1, 0, 4'b0001, 3'd2, 0, "b4_beat3");
    applyStimulus(4'b0001, 4'b0000, SEQ,    INCR4,  1, 0, 4'b0001, 3'd0, 0, "b4_beat4");
    applyStimulus(4'b0000, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b0001, 3'd0, 0, "b4_next");

    applyStimulus(4'b0010, 4'b0010, IDLE,   SINGLE, 1, 0, 4'b0010, 3'd0, 0, "lk_req");
    applyStimulus(4'b0010, 4'b0010, IDLE,   SINGLE, 1, 0, 4'b0010, 3'd1, 1, "lk_own");
    for (int t = 0; t < 2; t++) begin
      applyStimulus(4'b1010, 4'b0010, NONSEQ, SINGLE, 0, 0, 4'b0010, 3'd1, 1, "lk_wait_a");
      applyStimulus(4'b1010, 4'b0010, NONSEQ, SINGLE, 0, 0, 4'b0010, 3'd1, 1, "lk_wait_b");
      applyStimulus(4'b1010, 4'b0010, NONSEQ, SINGLE, 1, 0, 4'b0010, 3'd1, 1, "lk_accept");
    end
    applyStimulus(4'b1000, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b1000, 3'd1, 0, "lk_release");
    applyStimulus(4'b1000, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b1000, 3'd3, 0, "lk_m3");

    applyStimulus(4'b0001, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0001, 3'd3, 0, "er_req");
    applyStimulus(4'b0001, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0001, 3'd0, 0, "er_own");
    applyStimulus(4'b0011, 4'b0000, NONSEQ, INCR8,  1, 0, 4'b0001, 3'd0, 0, "er_beat1");
    applyStimulus(4'b0011, 4'b0000, SEQ,    INCR8,  1, 0, 4'b0001, 3'd0, 0, "er_beat2");
    applyStimulus(4'b0011, 4'b0000, SEQ,    INCR8,  0, 1, 4'b0001, 3'd0, 0, "er_err1");
    applyStimulus(4'b0011, 4'b0000, IDLE,   INCR8,  1, 1, 4'b0010, 3'd0, 0, "er_err2");
    applyStimulus(4'b0000, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0001, 3'd1, 0, "er_park");
    applyStimulus(4'b0000, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0001, 3'd0, 0, "er_park2");

`ifdef ARB_FIXED_PRIORITY_EN
    applyStimulus(4'b1010, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b0010, 3'd0, 0, "md1");
    applyStimulus(4'b1010, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b0010, 3'd1, 0, "md2");
    applyStimulus(4'b1010, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b0010, 3'd1, 0, "md3");
    applyStimulus(4'b1010, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b0010, 3'd1, 0, "md4");
`else
    applyStimulus(4'b1010, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b1000, 3'd0, 0, "md1");
    applyStimulus(4'b1010, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b0010, 3'd3, 0, "md2");
    applyStimulus(4'b1010, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b1000, 3'd1, 0, "md3");
    applyStimulus(4'b1010, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b0010, 3'd3, 0, "md4");
`endif
    applyStimulus(4'b0000, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0001, 3'd1, 0, "md_drop");
    applyStimulus(4'b0000, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0001, 3'd0, 0, "md_park");

    applyStimulus(4'b0100, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0100, 3'd0, 0, "b16_req");
    applyStimulus(4'b0100, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0100, 3'd2, 0, "b16_own");
    applyStimulus(4'b0101, 4'b0000, NONSEQ, INCR16, 1, 0, 4'b0100, 3'd2, 0, "b16_beat1");
    applyStimulus(4'b0101, 4'b0000, SEQ,    INCR16, 1, 0, 4'b0100, 3'd2, 0, "b16_beat2");
    #3;
    HRESETn = 1'b0;
    #1;
    checkOutput("b16_rst_grant", 32'(HGRANT), 32'h1);
    checkOutput("b16_rst_master", 32'(HMASTER), 32'h0);
    checkOutput("b16_rst_lock", 32'(HMASTLOCK), 32'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    applyStimulus(4'b0000, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0001, 3'd0, 0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
